mul_seq_ctrl: RTL
=================

Name: mul_seq_ctrl

Overview:
- Sequencer that drives the pipelined unsigned 16x16 hardware multiplier cell of the Nios II custom datapath to produce full 32x32 products.
- Accepts one multiply command at a time and issues 3 or 4 partial products to the cell on consecutive cycles.
- Accumulates the returned partial products into a 64-bit sum and applies sign correction.
- Returns either the low 32 bits (MUL) or the high 32 bits (MULXUU/MULXSS/MULXSU) over a valid/ready handshake.

Parameters:
- MUL_LAT, 2: cycles from cell_a/cell_b presented to cell_result valid; legal range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block accepts command; high only in IDLE.
- cmd_op  in  2  00 MUL, 01 MULXUU, 10 MULXSS, 11 MULXSU (src1 signed, src2 unsigned).
- cmd_src1  in  32  operand A.
- cmd_src2  in  32  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_result  out  32  selected 32-bit result.
- cell_a  out  16  multiplier cell operand A (unsigned).
- cell_b  out  16  multiplier cell operand B (unsigned).
- cell_result  in  32  unsigned product, MUL_LAT cycles after issue.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, rsp_valid 0, rsp_result 0, cell_a 0, cell_b 0, accumulator 0, in-flight tag pipe cleared. cmd_ready is 1 in the first cycle after reset deasserts.
- Accept: the handshake cmd_valid & cmd_ready in cycle T latches operands and op.
  - Signed operands (op 10 for both; op 11 for src1 only) are replaced by their magnitudes. 0x80000000 maps to magnitude 0x80000000.
  - The sign flag is the XOR of the signed operand sign bits.
- Partial products: let Al/Ah and Bl/Bh be the 16-bit halves of the magnitudes. Issue order and shifts:
  - 1: Al*Bl, shift 0.
  - 2: Ah*Bl, shift 16.
  - 3: Al*Bh, shift 16.
  - 4: Ah*Bh, shift 32; issued only when op != MUL.
  - N = 3 for MUL, N = 4 otherwise.
- FSM:
  - IDLE -> ISSUE on accept.
  - ISSUE: cycles T+1..T+N, one pair per cycle on cell_a/cell_b; -> DRAIN after the last issue.
  - DRAIN: waits for the last return at cycle T+N+MUL_LAT.
  - FIX: one cycle. If the sign flag is set, the 64-bit accumulator is two's-complement negated. rsp_result is loaded with acc[31:0] for MUL, acc[63:32] otherwise. -> RESP.
  - RESP: rsp_valid held high and rsp_result stable until rsp_ready. On the handshake -> IDLE.
- Return tracking: a MUL_LAT-deep shift register carries valid+shift tags alongside each issue. A returning cell_result is added, shifted, into the accumulator in the cycle it arrives. Untagged cell_result values are ignored.
- Arithmetic: 64-bit accumulator, modulo 2^64; no overflow is possible for unsigned magnitudes. MUL sign handling: the low 32 bits are sign-agnostic, so the sign flag is forced to 0 for MUL.
- Latency: rsp_valid first high in cycle T+N+MUL_LAT+2.
  - MUL, MUL_LAT=2: T+7.
  - MULX*, MUL_LAT=2: T+8.
- Throughput: with rsp_ready held high, the next accept is possible in the cycle after the response handshake.
- Simultaneous events: cmd_valid during any non-IDLE state is not accepted (cmd_ready=0). rsp_ready while rsp_valid=0 is ignored.
- Reset mid-operation: immediate return to IDLE and the tag pipe is cleared. Cell returns from pre-reset issues are discarded, and no rsp_valid is produced for the aborted command.
- cell_a/cell_b: hold 0 outside ISSUE.

Test Plan:
- MUL 0x00010003 * 0x00020005, rsp_ready=1 -> rsp_result 0x000B000F; rsp_valid at T+7; exactly 3 distinct cell_a/cell_b issues.
- MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE at T+8; MULXSS 0x80000000 * 0x80000000 -> 0x40000000.
- MULXSS 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000; MULXSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF; MUL 0xFFFFFFFE * 0x00000003 -> 0xFFFFFFFA.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises -> rsp_valid and rsp_result stable, cmd_ready 0, busy 1; accept possible the cycle after the handshake.
- Reset pulse at T+4 of a MULXUU -> rsp_valid never rises for it. A new MUL 3*5 issued right after reset returns 0x0000000F, uncorrupted by stale cell returns.
- Sweep MUL_LAT=1,3,4 with 200 random ops vs reference model -> every result matches; latency equals N+MUL_LAT+2.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a pipelined 16x16 unsigned multiplier cell producing 32x32 products.
// Issues 3 or 4 partial products, accumulates them into 64 bits and applies sign correction.
module mul_seq_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_src1,
    input  logic [31:0] cmd_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [15:0] cell_a,
    output logic [15:0] cell_b,
    input  logic [31:0] cell_result,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIX, S_RESP} state_t;

    // shift is in units of 16 bits: 0, 1 or 2
    typedef struct packed {
        logic       vld;
        logic       last;
        logic [1:0] shift;
    } tag_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_mag_q, a_mag_d;
    logic [31:0] b_mag_q, b_mag_d;
    logic        sign_q, sign_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    tag_t        pipe_q [MUL_LAT];
    tag_t        issue_tag;
    tag_t        ret_tag;

    logic        is_mul;
    logic        last_issue;
    logic        src1_neg;
    logic        src2_neg;
    logic [63:0] acc_fixed;

    assign ret_tag    = pipe_q[MUL_LAT-1];
    assign is_mul     = (op_q == OP_MUL);
    assign last_issue = (cnt_q == (is_mul ? 2'd2 : 2'd3));
    // src1 is signed for both MULXSS and MULXSU, which share op bit 1
    assign src1_neg   = cmd_op[1] & cmd_src1[31];
    assign src2_neg   = (cmd_op == OP_MULXSS) & cmd_src2[31];
    assign acc_fixed  = sign_q ? (~acc_q + 64'd1) : acc_q;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_result = rsp_result_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d      = state_q;
        op_d         = op_q;
        a_mag_d      = a_mag_q;
        b_mag_d      = b_mag_q;
        sign_d       = sign_q;
        cnt_d        = cnt_q;
        rsp_result_d = rsp_result_q;
        issue_tag    = '0;
        cell_a       = '0;
        cell_b       = '0;
        acc_d        = acc_q;
        if (ret_tag.vld) begin
            acc_d = acc_q + ({32'd0, cell_result} << {ret_tag.shift, 4'd0});
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_mag_d = src1_neg ? (~cmd_src1 + 32'd1) : cmd_src1;
                    b_mag_d = src2_neg ? (~cmd_src2 + 32'd1) : cmd_src2;
                    sign_d  = src1_neg ^ src2_neg;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                unique case (cnt_q)
                    2'd0: begin
                        cell_a = a_mag_q[15:0];  cell_b = b_mag_q[15:0];  issue_tag.shift = 2'd0;
                    end
                    2'd1: begin
                        cell_a = a_mag_q[31:16]; cell_b = b_mag_q[15:0];  issue_tag.shift = 2'd1;
                    end
                    2'd2: begin
                        cell_a = a_mag_q[15:0];  cell_b = b_mag_q[31:16]; issue_tag.shift = 2'd1;
                    end
                    default: begin
                        cell_a = a_mag_q[31:16]; cell_b = b_mag_q[31:16]; issue_tag.shift = 2'd2;
                    end
                endcase
                issue_tag.vld  = 1'b1;
                issue_tag.last = last_issue;
                cnt_d          = cnt_q + 2'd1;
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ret_tag.vld && ret_tag.last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                rsp_result_d = is_mul ? acc_fixed[31:0] : acc_fixed[63:32];
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_mag_q      <= '0;
            b_mag_q      <= '0;
            sign_q       <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            rsp_result_q <= '0;
            // NOTE: the tag pipe must be cleared on reset so returns from aborted issues are dropped.
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_mag_q      <= a_mag_d;
            b_mag_q      <= b_mag_d;
            sign_q       <= sign_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            rsp_result_q <= rsp_result_d;
            pipe_q[0]    <= issue_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

endmodule
